// File: rtl/coin_counter_ctrl.sv
// Coin beam sequencer: synchronises and debounces four coin beams, converts each
// debounced break into a coin event and keeps saturating cent/count totals.
module coin_counter_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SETTLE_CYCLES   = 500000,
    parameter int unsigned STUCK_CYCLES    = 5000000,
    parameter int unsigned TOTAL_W         = 32,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               io1,
    input  logic               io2,
    input  logic               io3,
    input  logic               io4,
    output logic [TOTAL_W-1:0] total_cents,
    output logic [CNT_W-1:0]   cnt_q,
    output logic [CNT_W-1:0]   cnt_d,
    output logic [CNT_W-1:0]   cnt_n,
    output logic [CNT_W-1:0]   cnt_p,
    output logic               coin_evt,
    output logic [5:0]         evt_value,
    output logic               running,
    output logic               fault
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SK_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SE_W-1:0] SE_LAST = SE_W'(SETTLE_CYCLES - 1);
    localparam logic [SK_W-1:0] SK_LAST = SK_W'(STUCK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, FAULT} state_t;

    state_t state, state_nx;

    logic [3:0]         beam_raw, sync1, sync2, stable, stable_d, brk, acc;
    logic [DB_W-1:0]    db_cnt [4];
    logic [SK_W-1:0]    stuck_cnt [4];
    logic [SE_W-1:0]    settle_cnt;
    logic               settle_done, stuck_hit;
    logic [5:0]         evt_sum;
    logic [TOTAL_W:0]   total_ext;
    logic [TOTAL_W-1:0] total_sat;
    logic [CNT_W-1:0]   cnt [4];

    // Bit i follows io(i+1): 0 = quarter, 1 = dime, 2 = nickel, 3 = penny
    assign beam_raw = {io4, io3, io2, io1};

    // Two-stage synchroniser, idles at the unbroken level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= beam_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level once it has differed from stable for DEBOUNCE_CYCLES
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable   <= '1;
            stable_d <= '1;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            stable_d <= stable;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A break is seen one edge after stable falls; only RUN turns it into a coin
    assign brk = stable_d & ~stable;
    assign acc = (state == RUN) ? brk : 4'b0000;

    // Settle timer runs only while in SETTLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state == SETTLE && !settle_done) begin
            settle_cnt <= settle_cnt + SE_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    assign settle_done = (settle_cnt == SE_LAST);

    // Per-beam stuck timers measure continuous stable-broken time within RUN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) stuck_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (state == RUN && !stable[i]) stuck_cnt[i] <= stuck_cnt[i] + SK_W'(1);
                else                            stuck_cnt[i] <= '0;
            end
        end
    end

    // Any beam that has been broken for the full stuck window
    always_comb begin
        stuck_hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!stable[i] && stuck_cnt[i] == SK_LAST) stuck_hit = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state and status outputs
    always_comb begin
        state_nx = state;
        running  = 1'b0;
        fault    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = SETTLE;
            end
            SETTLE: begin
                if (!start)          state_nx = IDLE;
                else if (settle_done) state_nx = (&stable) ? RUN : FAULT;
            end
            RUN: begin
                running = 1'b1;
                if (!start)         state_nx = IDLE;
                else if (stuck_hit) state_nx = FAULT;
            end
            FAULT: begin
                fault = 1'b1;
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Cent value of all coins accepted this cycle and the saturated new total
    always_comb begin
        evt_sum = 6'd0;
        if (acc[0]) evt_sum = evt_sum + 6'd25;
        if (acc[1]) evt_sum = evt_sum + 6'd10;
        if (acc[2]) evt_sum = evt_sum + 6'd5;
        if (acc[3]) evt_sum = evt_sum + 6'd1;
        total_ext = {1'b0, total_cents} + (TOTAL_W + 1)'(evt_sum);
        total_sat = total_ext[TOTAL_W] ? '1 : total_ext[TOTAL_W-1:0];
    end

    // Accumulators; clear takes priority over a coin in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total_cents <= '0;
            coin_evt    <= 1'b0;
            evt_value   <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (clear) begin
            total_cents <= '0;
            coin_evt    <= 1'b0;
            evt_value   <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (|acc) begin
            total_cents <= total_sat;
            coin_evt    <= 1'b1;
            evt_value   <= evt_sum;
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end else begin
            coin_evt <= 1'b0;
        end
    end

    assign cnt_q = cnt[0];
    assign cnt_d = cnt[1];
    assign cnt_n = cnt[2];
    assign cnt_p = cnt[3];

endmodule

// File: tb/tb_coin_counter_ctrl.sv
// Bench for coin_counter_ctrl: directed coin sequences, a cycle model built from
// the behavioural rules, per-cycle comparison plus hand-computed checkpoints.
module tb_coin_counter_ctrl;

    localparam int D  = 4;
    localparam int S  = 8;
    localparam int ST = 20;
    localparam int TW = 8;
    localparam int CW = 4;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_RUN    = 2;
    localparam int M_FAULT  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    iov   = 4'hF;
    logic [TW-1:0] total_cents;
    logic [CW-1:0] cnt_q, cnt_d, cnt_n, cnt_p;
    logic          coin_evt;
    logic [5:0]    evt_value;
    logic          running, fault;

    coin_counter_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SETTLE_CYCLES  (S),
        .STUCK_CYCLES   (ST),
        .TOTAL_W        (TW),
        .CNT_W          (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .io1        (iov[0]),
        .io2        (iov[1]),
        .io3        (iov[2]),
        .io4        (iov[3]),
        .total_cents(total_cents),
        .cnt_q      (cnt_q),
        .cnt_d      (cnt_d),
        .cnt_n      (cnt_n),
        .cnt_p      (cnt_p),
        .coin_evt   (coin_evt),
        .evt_value  (evt_value),
        .running    (running),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int npass = 0;
    int evt_seen = 0;
    bit armed = 0;

    // Model state
    logic [3:0] rawh [0:D];
    logic [3:0] ms, mpend;
    int         mmode;
    longint     n = 0;
    longint     ment;
    longint     since [4];
    int         mtotal, mval;
    int         mcnt [4];
    bit         mevt;
    int         coin_val [4] = '{25, 10, 5, 1};

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One clock edge of the behavioural model
    task automatic model_step();
        logic [3:0] nms, took;
        bit flip, stuck;
        int sum;
        if (reset) begin
            for (int j = 0; j <= D; j++) rawh[j] = 4'hF;
            ms = 4'hF; mpend = 4'h0; mmode = M_IDLE; ment = n;
            mtotal = 0; mval = 0; mevt = 0;
            for (int b = 0; b < 4; b++) begin mcnt[b] = 0; since[b] = n; end
        end else begin
            // a level is accepted after D consecutive synchronised samples disagree
            nms = ms;
            for (int b = 0; b < 4; b++) begin
                flip = 1;
                for (int j = 1; j <= D; j++) if (rawh[j][b] == ms[b]) flip = 0;
                if (flip) nms[b] = ~ms[b];
            end
            took = (mmode == M_RUN) ? mpend : 4'h0;
            if (clear) begin
                mtotal = 0; mval = 0; mevt = 0;
                for (int b = 0; b < 4; b++) mcnt[b] = 0;
            end else if (took != 4'h0) begin
                sum = 0;
                for (int b = 0; b < 4; b++) if (took[b]) begin
                    sum += coin_val[b];
                    mcnt[b] = (mcnt[b] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mcnt[b] + 1;
                end
                mtotal = (mtotal + sum > (1 << TW) - 1) ? (1 << TW) - 1 : mtotal + sum;
                mval = sum; mevt = 1;
            end else begin
                mevt = 0;
            end
            stuck = 0;
            for (int b = 0; b < 4; b++)
                if (mmode == M_RUN && !ms[b] && (n - since[b]) >= ST) stuck = 1;
            for (int b = 0; b < 4; b++)
                if (ms[b] || mmode != M_RUN) since[b] = n;
            case (mmode)
                M_IDLE:   if (start) begin mmode = M_SETTLE; ment = n; end
                M_SETTLE: if (!start) mmode = M_IDLE;
                          else if (n - ment == S) mmode = (ms == 4'hF) ? M_RUN : M_FAULT;
                M_RUN:    if (!start) mmode = M_IDLE; else if (stuck) mmode = M_FAULT;
                default:  if (!start) mmode = M_IDLE;
            endcase
            mpend = ms & ~nms;
            ms = nms;
            for (int j = D; j >= 1; j--) rawh[j] = rawh[j-1];
            rawh[0] = iov;
        end
        n++;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (armed && !reset) begin
            if (coin_evt) evt_seen++;
            chk("total_cents", total_cents, mtotal);
            chk("cnt_q", cnt_q, mcnt[0]);
            chk("cnt_d", cnt_d, mcnt[1]);
            chk("cnt_n", cnt_n, mcnt[2]);
            chk("cnt_p", cnt_p, mcnt[3]);
            chk("coin_evt", coin_evt, mevt);
            chk("evt_value", evt_value, mval);
            chk("running", running, mmode == M_RUN);
            chk("fault", fault, mmode == M_FAULT);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1; start = 0; clear = 0; iov = 4'hF;
        tick(2);
        reset = 0;
        armed = 1;
        tick(1);
    endtask

    // Hold one beam broken for len cycles, then release and let it settle
    task automatic coin(input int b, input int len);
        iov[b] = 1'b0;
        tick(len);
        iov[b] = 1'b1;
        tick(8);
    endtask

    int e0;

    initial begin
        tick(1);
        do_reset();
        chk("rst_total", total_cents, 0);
        chk("rst_running", running, 0);
        chk("rst_fault", fault, 0);
        chk("rst_evt", coin_evt, 0);

        // quarter after settle
        start = 1;
        tick(12);
        chk("t1_running", running, 1);
        e0 = evt_seen;
        coin(0, 10);
        tick(4);
        chk("t1_events", evt_seen - e0, 1);
        chk("t1_value", evt_value, 25);
        chk("t1_total", total_cents, 25);
        chk("t1_cnt_q", cnt_q, 1);

        // stop retains totals, restart re-settles
        start = 0;
        tick(2);
        chk("stop_running", running, 0);
        chk("stop_total", total_cents, 25);
        start = 1;
        tick(3);
        chk("resettle_running", running, 0);
        tick(9);
        chk("restart_running", running, 1);

        // nickel glitch ignored, dime counted
        clear = 1; tick(1); clear = 0; tick(1);
        e0 = evt_seen;
        iov[2] = 1'b0; tick(3); iov[2] = 1'b1; tick(10);
        chk("t2_glitch", evt_seen - e0, 0);
        coin(1, 10);
        tick(4);
        chk("t2_events", evt_seen - e0, 1);
        chk("t2_value", evt_value, 10);
        chk("t2_total", total_cents, 10);
        chk("t2_cnt_n", cnt_n, 0);

        // all four beams at once
        clear = 1; tick(1); clear = 0; tick(1);
        e0 = evt_seen;
        iov = 4'h0; tick(10); iov = 4'hF; tick(12);
        chk("t3_events", evt_seen - e0, 1);
        chk("t3_value", evt_value, 41);
        chk("t3_total", total_cents, 41);
        chk("t3_cnts", {cnt_q, cnt_d, cnt_n, cnt_p}, 16'h1111);

        // asynchronous reset mid-cycle while running
        #2;
        reset = 1;
        #1;
        chk("async_total", total_cents, 0);
        chk("async_running", running, 0);
        tick(2);
        reset = 0; start = 0; iov = 4'hF;
        tick(1);

        // penny beam broken before start -> fault after settle
        iov[3] = 1'b0;
        tick(10);
        start = 1;
        tick(12);
        chk("t4_fault", fault, 1);
        chk("t4_running", running, 0);
        chk("t4_total", total_cents, 0);
        start = 0;
        tick(2);
        chk("t4_fault_clr", fault, 0);
        iov = 4'hF;
        tick(10);

        // dime held long -> one coin, then stuck fault
        do_reset();
        start = 1;
        tick(12);
        e0 = evt_seen;
        iov[1] = 1'b0;
        tick(30);
        chk("t5_fault", fault, 1);
        chk("t5_events", evt_seen - e0, 1);
        chk("t5_total", total_cents, 10);
        iov = 4'hF; start = 0;
        tick(10);

        // saturation with an 8-bit total and 4-bit counts
        do_reset();
        start = 1;
        tick(12);
        repeat (10) coin(0, 8);
        chk("t6_total250", total_cents, 250);
        e0 = evt_seen;
        coin(0, 8);
        chk("t6_total_sat", total_cents, 255);
        chk("t6_evt_sat", evt_seen - e0, 1);
        chk("t6_cnt_q11", cnt_q, 11);
        repeat (5) coin(0, 8);
        chk("t6_cnt_sat", cnt_q, 15);
        chk("t6_total_hold", total_cents, 255);

        // clear coincident with the edge the quarter would be counted
        e0 = evt_seen;
        iov[0] = 1'b0;
        tick(6);
        clear = 1;
        tick(1);
        clear = 0;
        tick(10);
        iov = 4'hF;
        tick(10);
        chk("t6_clr_total", total_cents, 0);
        chk("t6_clr_cnt_q", cnt_q, 0);
        chk("t6_clr_events", evt_seen - e0, 0);
        chk("t6_clr_value", evt_value, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
